// File: rtl/uart_channel_arbiter.sv
// Shares one uart_comm link between two requesters: round-robin framed TX
// into the send FIFO, header-parsed RX demultiplexed back to the channels.
module uart_channel_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    input  logic [2:0]  req0_len,
    input  logic [63:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_len,
    input  logic [63:0] req1_data,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [2:0]  rsp0_len,
    output logic [63:0] rsp0_data,
    output logic        rsp1_valid,
    output logic [2:0]  rsp1_len,
    output logic [63:0] rsp1_data,
    output logic        rx_error,
    output logic        uart_send_flag,
    output logic [7:0]  uart_send_data,
    input  logic        uart_sendable,
    output logic        uart_recv_flag,
    input  logic [7:0]  uart_recv_data,
    input  logic        uart_receivable
);

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_DATA} tx_state_t;
    typedef enum logic {R_HDR, R_DATA} rx_state_t;

    // ---------------- TX path ----------------
    tx_state_t   tx_state_reg, tx_state_next;
    logic        rr_last_reg, rr_last_next;
    logic        tx_ch_reg, tx_ch_next;
    logic [2:0]  tx_len_reg, tx_len_next;
    logic [2:0]  tx_idx_reg, tx_idx_next;
    logic [63:0] tx_data_reg, tx_data_next;
    logic        req0_ready_reg, req0_ready_next;
    logic        req1_ready_reg, req1_ready_next;
    logic        tx_grant;
    logic [7:0]  tx_byte [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tx_byte
            assign tx_byte[gi] = tx_data_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        tx_state_next   = tx_state_reg;
        rr_last_next    = rr_last_reg;
        tx_ch_next      = tx_ch_reg;
        tx_len_next     = tx_len_reg;
        tx_idx_next     = tx_idx_reg;
        tx_data_next    = tx_data_reg;
        req0_ready_next = 1'b0;
        req1_ready_next = 1'b0;
        tx_grant        = 1'b0;
        uart_send_flag  = 1'b0;
        uart_send_data  = 8'h00;
        case (tx_state_reg)
            T_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // Under contention the channel not served last wins.
                    tx_grant        = (req0_valid && req1_valid) ? ~rr_last_reg : req1_valid;
                    rr_last_next    = tx_grant;
                    tx_ch_next      = tx_grant;
                    tx_len_next     = tx_grant ? req1_len : req0_len;
                    tx_data_next    = tx_grant ? req1_data : req0_data;
                    req0_ready_next = ~tx_grant;
                    req1_ready_next = tx_grant;
                    tx_state_next   = T_HDR;
                end
            end
            T_HDR: begin
                uart_send_flag = uart_sendable;
                uart_send_data = {tx_ch_reg, 4'b0000, tx_len_reg};
                if (uart_sendable) begin
                    tx_idx_next   = 3'd0;
                    tx_state_next = T_DATA;
                end
            end
            T_DATA: begin
                uart_send_flag = uart_sendable;
                uart_send_data = tx_byte[tx_idx_reg];
                if (uart_sendable) begin
                    if (tx_idx_reg == tx_len_reg) begin
                        tx_state_next = T_IDLE;
                    end else begin
                        tx_idx_next = tx_idx_reg + 3'd1;
                    end
                end
            end
            default: tx_state_next = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state_reg   <= T_IDLE;
            rr_last_reg    <= 1'b1;
            tx_ch_reg      <= 1'b0;
            tx_len_reg     <= 3'd0;
            tx_idx_reg     <= 3'd0;
            tx_data_reg    <= 64'd0;
            req0_ready_reg <= 1'b0;
            req1_ready_reg <= 1'b0;
        end else begin
            tx_state_reg   <= tx_state_next;
            rr_last_reg    <= rr_last_next;
            tx_ch_reg      <= tx_ch_next;
            tx_len_reg     <= tx_len_next;
            tx_idx_reg     <= tx_idx_next;
            tx_data_reg    <= tx_data_next;
            req0_ready_reg <= req0_ready_next;
            req1_ready_reg <= req1_ready_next;
        end
    end

    assign req0_ready = req0_ready_reg;
    assign req1_ready = req1_ready_reg;

    // ---------------- RX path ----------------
    rx_state_t   rx_state_reg, rx_state_next;
    logic        pop_wait_reg;
    logic        rx_ch_reg, rx_ch_next;
    logic [2:0]  rx_len_reg, rx_len_next;
    logic [2:0]  rx_idx_reg, rx_idx_next;
    logic [63:0] rx_buf_reg, rx_buf_next;
    logic        rx_error_reg, rx_error_next;
    logic        rsp_fire;
    logic [7:0]  rx_asm_byte [8];
    logic [63:0] rx_asm;
    logic        rsp0_valid_reg, rsp1_valid_reg;
    logic [2:0]  rsp0_len_reg, rsp1_len_reg;
    logic [63:0] rsp0_data_reg, rsp1_data_reg;

    // pop_wait blocks the cycle after a pop so the FIFO head has settled.
    assign uart_recv_flag = uart_receivable & ~pop_wait_reg;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_rx_byte
            assign rx_asm_byte[gi] = (rx_idx_reg == 3'(gi)) ? uart_recv_data
                                                            : rx_buf_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rx_asm = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rx_asm[8*i +: 8] = rx_asm_byte[i];
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_ch_next    = rx_ch_reg;
        rx_len_next   = rx_len_reg;
        rx_idx_next   = rx_idx_reg;
        rx_buf_next   = rx_buf_reg;
        rx_error_next = 1'b0;
        rsp_fire      = 1'b0;
        case (rx_state_reg)
            R_HDR: begin
                if (uart_recv_flag) begin
                    if (uart_recv_data[6:3] != 4'd0) begin
                        rx_error_next = 1'b1;
                    end else begin
                        rx_ch_next    = uart_recv_data[7];
                        rx_len_next   = uart_recv_data[2:0];
                        rx_idx_next   = 3'd0;
                        rx_buf_next   = 64'd0;
                        rx_state_next = R_DATA;
                    end
                end
            end
            R_DATA: begin
                if (uart_recv_flag) begin
                    rx_buf_next = rx_asm;
                    if (rx_idx_reg == rx_len_reg) begin
                        rsp_fire      = 1'b1;
                        rx_state_next = R_HDR;
                    end else begin
                        rx_idx_next = rx_idx_reg + 3'd1;
                    end
                end
            end
            default: rx_state_next = R_HDR;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_state_reg   <= R_HDR;
            pop_wait_reg   <= 1'b0;
            rx_ch_reg      <= 1'b0;
            rx_len_reg     <= 3'd0;
            rx_idx_reg     <= 3'd0;
            rx_buf_reg     <= 64'd0;
            rx_error_reg   <= 1'b0;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp0_len_reg   <= 3'd0;
            rsp1_len_reg   <= 3'd0;
            rsp0_data_reg  <= 64'd0;
            rsp1_data_reg  <= 64'd0;
        end else begin
            rx_state_reg   <= rx_state_next;
            pop_wait_reg   <= uart_recv_flag;
            rx_ch_reg      <= rx_ch_next;
            rx_len_reg     <= rx_len_next;
            rx_idx_reg     <= rx_idx_next;
            rx_buf_reg     <= rx_buf_next;
            rx_error_reg   <= rx_error_next;
            rsp0_valid_reg <= rsp_fire & ~rx_ch_reg;
            rsp1_valid_reg <= rsp_fire & rx_ch_reg;
            if (rsp_fire && !rx_ch_reg) begin
                rsp0_len_reg  <= rx_len_reg;
                rsp0_data_reg <= rx_asm;
            end
            if (rsp_fire && rx_ch_reg) begin
                rsp1_len_reg  <= rx_len_reg;
                rsp1_data_reg <= rx_asm;
            end
        end
    end

    assign rsp0_valid = rsp0_valid_reg;
    assign rsp1_valid = rsp1_valid_reg;
    assign rsp0_len   = rsp0_len_reg;
    assign rsp1_len   = rsp1_len_reg;
    assign rsp0_data  = rsp0_data_reg;
    assign rsp1_data  = rsp1_data_reg;
    assign rx_error   = rx_error_reg;

endmodule
